// File: rtl/light_conflict_monitor.sv
// rtl/light_conflict_monitor.sv - watches the main/side/walk lamp outputs and latches the first safety violation
// Per-direction RED/GREEN/YELLOW trackers and yellow timers feed the registered fault flag, code and count.

module light_conflict_monitor #(
   parameter int MIN_YELLOW = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable_1Hz,
   input  logic       Rm,
   input  logic       Ym,
   input  logic       Gm,
   input  logic       Rs,
   input  logic       Ys,
   input  logic       Gs,
   input  logic       W,
   input  logic       fault_clear,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [7:0] fault_count
);

   typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2} light_t;

   localparam logic [3:0] MIN_Y = 4'(MIN_YELLOW);

   light_t     st     [2];
   light_t     samp   [2];
   logic [3:0] ytmr   [2];
   logic [2:0] lamp   [2];
   logic [1:0] valid;
   logic [1:0] onehot;
   logic [1:0] bad_trans;
   logic [1:0] short_y;
   logic [7:1] viol;
   logic [2:0] code;
   logic       any_viol;

   // Index 0 is the main street, index 1 the side street.
   always_comb begin
      lamp[0] = {Rm, Ym, Gm};
      lamp[1] = {Rs, Ys, Gs};
      onehot    = '0;
      bad_trans = '0;
      short_y   = '0;
      for (int d = 0; d < 2; d++) begin
         onehot[d] = (lamp[d] == 3'b001) || (lamp[d] == 3'b010) || (lamp[d] == 3'b100);
         samp[d]   = lamp[d][2] ? RED : (lamp[d][1] ? YELLOW : GREEN);
         bad_trans[d] = valid[d] && onehot[d] &&
                        !((samp[d] == st[d]) ||
                          (st[d] == GREEN  && samp[d] == YELLOW) ||
                          (st[d] == YELLOW && samp[d] == RED) ||
                          (st[d] == RED    && samp[d] == GREEN));
         short_y[d] = valid[d] && onehot[d] && (st[d] == YELLOW) &&
                      (samp[d] == RED) && (ytmr[d] < MIN_Y);
      end
      viol[1] = !onehot[0];
      viol[2] = !onehot[1];
      viol[3] = (Gm | Ym) & (Gs | Ys);
      viol[4] = W & !(Rm & Rs);
      viol[5] = bad_trans[0];
      viol[6] = bad_trans[1];
      viol[7] = |short_y;
      any_viol = |viol;
      // Walk downwards so the lowest-numbered firing code wins.
      code = 3'd0;
      for (int i = 7; i >= 1; i--) begin
         if (viol[i]) code = 3'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fault       <= 1'b0;
         fault_code  <= 3'd0;
         fault_count <= 8'd0;
         valid       <= 2'b00;
         for (int d = 0; d < 2; d++) begin
            st[d]   <= RED;
            ytmr[d] <= 4'd0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (onehot[d]) begin
               st[d]    <= samp[d];
               valid[d] <= 1'b1;
            end
            if (onehot[d] && samp[d] == YELLOW && st[d] != YELLOW)
               ytmr[d] <= 4'd0;
            else if (st[d] == YELLOW && enable_1Hz && ytmr[d] != 4'hF)
               ytmr[d] <= ytmr[d] + 4'd1;
         end

         if (any_viol && fault_count != 8'hFF)
            fault_count <= fault_count + 8'd1;

         // A clear re-arms the latch, so a violation in the same cycle is captured fresh.
         if (fault_clear) begin
            fault      <= any_viol;
            fault_code <= any_viol ? code : 3'd0;
         end else if (any_viol && !fault) begin
            fault      <= 1'b1;
            fault_code <= code;
         end
      end
   end

endmodule

// File: tb/tb_light_conflict_monitor.sv
// tb/tb_light_conflict_monitor.sv - self-checking bench for light_conflict_monitor
// Each step row carries {reset, lamps, enable_1Hz, fault_clear, fault, code, count}; expectations go through a queue.

module tb_light_conflict_monitor;

   logic       clk = 1'b0;
   logic       reset, enable_1Hz, fault_clear;
   logic       Rm, Ym, Gm, Rs, Ys, Gs, W;
   logic       fault;
   logic [2:0] fault_code;
   logic [7:0] fault_count;

   int checks = 0;
   int errors = 0;
   logic [11:0] exp_q [$];

   // Lamp patterns as {Rm,Ym,Gm,Rs,Ys,Gs,W}.
   localparam logic [6:0] GM_RS   = 7'b001_100_0;
   localparam logic [6:0] YM_RS   = 7'b010_100_0;
   localparam logic [6:0] RM_RS   = 7'b100_100_0;
   localparam logic [6:0] RM_RS_W = 7'b100_100_1;
   localparam logic [6:0] RM_GS   = 7'b100_001_0;
   localparam logic [6:0] RM_YS   = 7'b100_010_0;
   localparam logic [6:0] GM_GS   = 7'b001_001_0;
   localparam logic [6:0] GM_RS_W = 7'b001_100_1;
   localparam logic [6:0] YM_RS_W = 7'b010_100_1;

   always #5 clk = ~clk;

   light_conflict_monitor #(.MIN_YELLOW(2)) dut (
      .clk(clk), .reset(reset), .enable_1Hz(enable_1Hz),
      .Rm(Rm), .Ym(Ym), .Gm(Gm), .Rs(Rs), .Ys(Ys), .Gs(Gs), .W(W),
      .fault_clear(fault_clear), .fault(fault), .fault_code(fault_code),
      .fault_count(fault_count)
   );

   function automatic logic [21:0] mk(input logic r, input logic [6:0] l, input logic en,
                                      input logic clr, input logic f, input logic [2:0] c,
                                      input logic [7:0] n);
      return {r, l, en, clr, f, c, n};
   endfunction

   task automatic drive(input logic [21:0] s);
      reset = s[21];
      {Rm, Ym, Gm, Rs, Ys, Gs, W} = s[20:14];
      enable_1Hz  = s[13];
      fault_clear = s[12];
   endtask

   task automatic test_reset();
      logic [21:0] seq [$];
      logic [11:0] e, got;
      seq = '{mk(1, GM_GS,   1, 1, 0, 0, 0),
              mk(1, YM_RS_W, 0, 0, 0, 0, 0),
              mk(0, RM_RS,   0, 0, 0, 0, 0),
              mk(0, RM_RS,   0, 0, 0, 0, 0)};
      foreach (seq[i]) begin
         drive(seq[i]);
         exp_q.push_back(seq[i][11:0]);
         @(posedge clk); @(negedge clk);
         e = exp_q.pop_front();
         got = {fault, fault_code, fault_count};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reset step %0d: got fault=%0b code=%0d count=%0d, expected fault=%0b code=%0d count=%0d",
                     i, got[11], got[10:8], got[7:0], e[11], e[10:8], e[7:0]);
         end
      end
   endtask

   task automatic test_legal_cycle();
      logic [21:0] seq [$];
      logic [11:0] e, got;
      seq = '{mk(1, RM_RS,   0, 0, 0, 0, 0),
              mk(0, GM_RS,   0, 0, 0, 0, 0),
              mk(0, YM_RS,   0, 0, 0, 0, 0),
              mk(0, YM_RS,   1, 0, 0, 0, 0),
              mk(0, YM_RS,   0, 0, 0, 0, 0),
              mk(0, YM_RS,   1, 0, 0, 0, 0),
              mk(0, YM_RS,   1, 0, 0, 0, 0),
              mk(0, RM_RS_W, 0, 0, 0, 0, 0),
              mk(0, RM_GS,   0, 0, 0, 0, 0),
              mk(0, RM_YS,   0, 0, 0, 0, 0),
              mk(0, RM_YS,   1, 0, 0, 0, 0),
              mk(0, RM_YS,   1, 0, 0, 0, 0),
              mk(0, RM_YS,   1, 0, 0, 0, 0),
              mk(0, RM_RS,   0, 0, 0, 0, 0),
              mk(0, GM_RS,   0, 0, 0, 0, 0)};
      foreach (seq[i]) begin
         drive(seq[i]);
         exp_q.push_back(seq[i][11:0]);
         @(posedge clk); @(negedge clk);
         e = exp_q.pop_front();
         got = {fault, fault_code, fault_count};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL legal_cycle step %0d: got fault=%0b code=%0d count=%0d, expected fault=%0b code=%0d count=%0d",
                     i, got[11], got[10:8], got[7:0], e[11], e[10:8], e[7:0]);
         end
      end
   endtask

   task automatic test_conflict_and_priority();
      logic [21:0] seq [$];
      logic [11:0] e, got;
      seq = '{mk(1, RM_RS,       0, 0, 0, 0, 0),
              mk(0, GM_RS,       0, 0, 0, 0, 0),
              mk(0, GM_GS,       0, 0, 1, 3, 1),
              mk(0, GM_RS,       0, 0, 1, 3, 2),
              mk(1, RM_RS,       0, 0, 0, 0, 0),
              mk(0, GM_RS,       0, 0, 0, 0, 0),
              mk(0, 7'b110_001_1, 0, 0, 1, 1, 1)};
      foreach (seq[i]) begin
         drive(seq[i]);
         exp_q.push_back(seq[i][11:0]);
         @(posedge clk); @(negedge clk);
         e = exp_q.pop_front();
         got = {fault, fault_code, fault_count};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL conflict_priority step %0d: got fault=%0b code=%0d count=%0d, expected fault=%0b code=%0d count=%0d",
                     i, got[11], got[10:8], got[7:0], e[11], e[10:8], e[7:0]);
         end
      end
   endtask

   task automatic test_yellow_timing();
      logic [21:0] seq [$];
      logic [11:0] e, got;
      seq = '{mk(1, RM_RS, 0, 0, 0, 0, 0),
              mk(0, GM_RS, 0, 0, 0, 0, 0),
              mk(0, YM_RS, 0, 0, 0, 0, 0),
              mk(0, YM_RS, 1, 0, 0, 0, 0),
              mk(0, RM_RS, 0, 0, 1, 7, 1),
              mk(0, GM_RS, 0, 0, 1, 7, 1),
              mk(0, RM_RS, 0, 0, 1, 7, 2),
              mk(1, RM_RS, 0, 0, 0, 0, 0),
              mk(0, GM_RS, 0, 0, 0, 0, 0),
              mk(0, YM_RS, 1, 0, 0, 0, 0),
              mk(0, YM_RS, 1, 0, 0, 0, 0),
              mk(0, YM_RS, 1, 0, 0, 0, 0),
              mk(0, RM_RS, 0, 0, 0, 0, 0),
              mk(0, RM_GS, 0, 0, 0, 0, 0),
              mk(0, RM_YS, 0, 0, 0, 0, 0),
              mk(0, RM_YS, 1, 0, 0, 0, 0),
              mk(0, RM_RS, 0, 0, 1, 7, 1)};
      foreach (seq[i]) begin
         drive(seq[i]);
         exp_q.push_back(seq[i][11:0]);
         @(posedge clk); @(negedge clk);
         e = exp_q.pop_front();
         got = {fault, fault_code, fault_count};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL yellow_timing step %0d: got fault=%0b code=%0d count=%0d, expected fault=%0b code=%0d count=%0d",
                     i, got[11], got[10:8], got[7:0], e[11], e[10:8], e[7:0]);
         end
      end
   endtask

   task automatic test_fault_clear();
      logic [21:0] seq [$];
      logic [11:0] e, got;
      seq = '{mk(1, RM_RS,        0, 0, 0, 0, 0),
              mk(0, GM_RS,        0, 0, 0, 0, 0),
              mk(0, GM_RS_W,      0, 0, 1, 4, 1),
              mk(0, GM_RS,        0, 1, 0, 0, 1),
              mk(0, GM_RS,        0, 0, 0, 0, 1),
              mk(0, GM_RS_W,      0, 0, 1, 4, 2),
              mk(0, 7'b011_100_0, 0, 1, 1, 1, 3),
              mk(0, GM_RS,        0, 0, 1, 1, 3)};
      foreach (seq[i]) begin
         drive(seq[i]);
         exp_q.push_back(seq[i][11:0]);
         @(posedge clk); @(negedge clk);
         e = exp_q.pop_front();
         got = {fault, fault_code, fault_count};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL fault_clear step %0d: got fault=%0b code=%0d count=%0d, expected fault=%0b code=%0d count=%0d",
                     i, got[11], got[10:8], got[7:0], e[11], e[10:8], e[7:0]);
         end
      end
   endtask

   task automatic test_reset_mid_yellow();
      logic [21:0] seq [$];
      logic [11:0] e, got;
      seq = '{mk(1, RM_RS,        0, 0, 0, 0, 0),
              mk(0, GM_RS,        0, 0, 0, 0, 0),
              mk(0, YM_RS,        0, 0, 0, 0, 0),
              mk(0, YM_RS,        1, 0, 0, 0, 0),
              mk(0, YM_RS_W,      0, 0, 1, 4, 1),
              mk(1, 7'b001_001_1, 1, 1, 0, 0, 0),
              mk(0, GM_RS,        0, 0, 0, 0, 0),
              mk(0, GM_RS,        0, 0, 0, 0, 0),
              mk(0, YM_RS,        0, 0, 0, 0, 0),
              mk(0, RM_RS,        0, 0, 1, 7, 1)};
      foreach (seq[i]) begin
         drive(seq[i]);
         exp_q.push_back(seq[i][11:0]);
         @(posedge clk); @(negedge clk);
         e = exp_q.pop_front();
         got = {fault, fault_code, fault_count};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reset_mid_yellow step %0d: got fault=%0b code=%0d count=%0d, expected fault=%0b code=%0d count=%0d",
                     i, got[11], got[10:8], got[7:0], e[11], e[10:8], e[7:0]);
         end
      end
   endtask

   task automatic test_count_saturation();
      logic [21:0] s;
      logic [11:0] e, got;
      for (int i = 0; i < 262; i++) begin
         if (i == 0)        s = mk(1, RM_RS,   0, 0, 0, 0, 0);
         else if (i == 1)   s = mk(0, GM_RS,   0, 0, 0, 0, 0);
         else if (i < 260)  s = mk(0, GM_RS_W, 0, 0, 1, 4, (i - 1 > 255) ? 8'd255 : 8'(i - 1));
         else if (i == 260) s = mk(0, GM_RS,   0, 1, 0, 0, 8'd255);
         else               s = mk(0, GM_RS_W, 0, 0, 1, 4, 8'd255);
         drive(s);
         exp_q.push_back(s[11:0]);
         @(posedge clk); @(negedge clk);
         e = exp_q.pop_front();
         got = {fault, fault_code, fault_count};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL count_saturation step %0d: got fault=%0b code=%0d count=%0d, expected fault=%0b code=%0d count=%0d",
                     i, got[11], got[10:8], got[7:0], e[11], e[10:8], e[7:0]);
         end
      end
   endtask

   initial begin
      drive(mk(1, RM_RS, 0, 0, 0, 0, 0));
      test_reset();
      test_legal_cycle();
      test_conflict_and_priority();
      test_yellow_timing();
      test_fault_clear();
      test_reset_mid_yellow();
      test_count_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
